// File: rtl/decrypt_word_packer_pkg.sv
// Shared constants and the FIFO entry type for the decrypted-byte word packer.
//   PACK_WORD_BYTES : default bytes per packed output word
//   PACK_FIFO_DEPTH : default number of buffered words
//   pack_word_t     : packed word payload plus count of valid bytes
package decrypt_word_packer_pkg;

  localparam int unsigned PACK_WORD_BYTES = 4;
  localparam int unsigned PACK_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [PACK_WORD_BYTES*8-1:0] data;
    logic [2:0]                   nbytes;
  } pack_word_t;

endpackage

// File: rtl/decrypt_word_packer_fifo.sv
// First-word-fall-through FIFO for packed words.
//   clk, rst    : clock, asynchronous active-high reset
//   i_push      : write request (i_wdata)
//   i_pop_req   : consumer accepts head; ignored while empty
//   o_head      : head entry, all-zero while empty
//   o_valid     : FIFO not empty
//   o_full      : level == DEPTH
//   o_level     : entries held
//   o_overflow  : sticky, a push was dropped because the FIFO was full
module decrypt_word_packer_fifo
  import decrypt_word_packer_pkg::*;
#(
  parameter type         entry_t = pack_word_t,
  parameter int unsigned DEPTH   = PACK_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  entry_t           i_wdata,
  input  logic             i_pop_req,
  output entry_t           o_head,
  output logic             o_valid,
  output logic             o_full,
  output logic [LVL_W-1:0] o_level,
  output logic             o_overflow
);

  entry_t           r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr_en;
  logic w_drop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop_req && !w_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign w_wr_en = i_push && (!w_full || w_pop);
  assign w_drop  = i_push && w_full && !w_pop;

  // Storage, pointers, level and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid    = !w_empty;
  assign o_full     = (r_level == LVL_W'(DEPTH));
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/decrypt_word_packer.sv
// Packs the decrypt pipeline's byte stream into little-endian words and buffers them.
//   clk, rst     : clock, asynchronous active-high reset
//   v_in, din    : decrypted byte and its valid (no back-pressure on this side)
//   flush        : push the pending partial word (including a same-cycle byte)
//   dout         : head word, zero while dout_valid=0
//   dout_nbytes  : valid bytes in dout, zero while dout_valid=0
//   dout_valid   : head present
//   dout_ready   : consumer accepts head
//   full, level  : buffer occupancy
//   overflow     : sticky, a completed word was dropped
module decrypt_word_packer
  import decrypt_word_packer_pkg::*;
#(
  parameter int unsigned WORD_BYTES = PACK_WORD_BYTES,
  parameter int unsigned FIFO_DEPTH = PACK_FIFO_DEPTH,
  localparam int unsigned WORD_W    = WORD_BYTES * 8,
  localparam int unsigned NB_W      = $clog2(WORD_BYTES + 1),
  localparam int unsigned CNT_W     = $clog2(WORD_BYTES),
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_in,
  input  logic [7:0]        din,
  input  logic              flush,
  output logic [WORD_W-1:0] dout,
  output logic [NB_W-1:0]   dout_nbytes,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              full,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [NB_W-1:0]   nbytes;
  } word_t;

  logic [CNT_W-1:0]  r_byte_cnt;
  logic [WORD_W-1:0] r_asm;

  logic [WORD_W-1:0] w_asm_ins;
  logic              w_last;
  logic              w_push;
  word_t             w_word;
  word_t             w_head;

  // Assembly with the current byte dropped into lane r_byte_cnt; higher lanes are still zero.
  always_comb begin
    w_asm_ins = r_asm;
    if (v_in) w_asm_ins = r_asm | (WORD_W'(din) << {r_byte_cnt, 3'b000});
  end

  assign w_last        = v_in && (r_byte_cnt == CNT_W'(WORD_BYTES - 1));
  assign w_push        = w_last || (flush && ((r_byte_cnt != '0) || v_in));
  assign w_word.data   = w_asm_ins;
  assign w_word.nbytes = NB_W'(r_byte_cnt) + NB_W'(v_in);

  // Byte counter and assembly register; cleared whenever a word leaves for the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (w_push) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (v_in) begin
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      r_asm      <= w_asm_ins;
    end
  end

  decrypt_word_packer_fifo #(
    .entry_t (word_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_wdata    (w_word),
    .i_pop_req  (dout_ready),
    .o_head     (w_head),
    .o_valid    (dout_valid),
    .o_full     (full),
    .o_level    (level),
    .o_overflow (overflow)
  );

  assign dout        = w_head.data;
  assign dout_nbytes = w_head.nbytes;

endmodule

// File: tb/tb_decrypt_word_packer.sv
module tb_decrypt_word_packer;

  localparam int WB    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_in = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        flush = 1'b0;
  logic        dout_ready = 1'b0;
  logic [31:0] dout;
  logic [2:0]  dout_nbytes;
  logic        dout_valid;
  logic        full;
  logic [2:0]  level;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  decrypt_word_packer #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .v_in(v_in), .din(din), .flush(flush),
    .dout(dout), .dout_nbytes(dout_nbytes), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .full(full), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending bytes, queue of finished words, sticky overflow.
  typedef struct {
    logic [31:0] d;
    int          nb;
  } mw_t;

  logic [7:0] m_pend[$];
  mw_t        m_fifo[$];
  bit         m_ovf = 0;

  function automatic logic [31:0] exp_dout();
    return (m_fifo.size() > 0) ? m_fifo[0].d : 32'h0;
  endfunction

  function automatic logic [2:0] exp_nb();
    return (m_fifo.size() > 0) ? 3'(m_fifo[0].nb) : 3'd0;
  endfunction

  function automatic void model_clear();
    m_pend.delete();
    m_fifo.delete();
    m_ovf = 0;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return 1ns after it.
  task automatic cyc(input bit v, input logic [7:0] d, input bit fl, input bit rdy);
    bit  pop, push, was_full;
    mw_t w;
    v_in = v; din = d; flush = fl; dout_ready = rdy;
    @(posedge clk);
    was_full = (m_fifo.size() == DEPTH);
    pop      = (m_fifo.size() > 0) && rdy;
    push     = 0;
    if (v) m_pend.push_back(d);
    if (m_pend.size() == WB || (fl && m_pend.size() > 0)) begin
      w.d  = 32'h0;
      w.nb = m_pend.size();
      for (int i = 0; i < m_pend.size(); i++) w.d[8*i +: 8] = m_pend[i];
      m_pend.delete();
      push = 1;
    end
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (!was_full || pop) m_fifo.push_back(w);
      else m_ovf = 1;
    end
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    v_in = 0; flush = 0; dout_ready = 0;
    #2 rst = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    checks++; if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (dout_nbytes !== 3'd0) begin failures++; $display("FAIL reset_nbytes got=%0d exp=0", dout_nbytes); end
    checks++; if (level !== 3'd0 || full !== 1'b0) begin failures++; $display("FAIL reset_level got=%0d/%b exp=0/0", level, full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    #11;
    release_reset();
  endtask

  task automatic test_full_word();
    cyc(1, 8'h11, 0, 1);
    cyc(1, 8'h22, 0, 1);
    cyc(1, 8'h33, 0, 1);
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL word_early_valid got=%b exp=0", dout_valid); end
    cyc(1, 8'h44, 0, 1);
    checks++; if (dout_valid !== 1'b1 || dout !== 32'h44332211) begin failures++; $display("FAIL word_dout got=%b/%h exp=1/44332211", dout_valid, dout); end
    checks++; if (dout_nbytes !== 3'd4) begin failures++; $display("FAIL word_nbytes got=%0d exp=4", dout_nbytes); end
    cyc(0, 8'h00, 0, 1);
    checks++; if (dout_valid !== 1'b0 || dout !== 32'h0) begin failures++; $display("FAIL word_one_cycle got=%b/%h exp=0/0", dout_valid, dout); end
  endtask

  task automatic test_flush();
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'hBB, 0, 0);
    cyc(0, 8'h00, 1, 0);
    checks++; if (dout !== 32'h0000BBAA || dout_nbytes !== 3'd2) begin failures++; $display("FAIL flush_partial got=%h/%0d exp=0000bbaa/2", dout, dout_nbytes); end
    cyc(0, 8'h00, 1, 1);
    checks++; if (dout_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL flush_noop got=%b/%0d exp=0/0", dout_valid, level); end
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'hBB, 0, 0);
    cyc(1, 8'hCC, 1, 0);
    checks++; if (dout !== 32'h00CCBBAA || dout_nbytes !== 3'd3 || level !== 3'd1) begin failures++; $display("FAIL flush_with_byte got=%h/%0d/%0d exp=00ccbbaa/3/1", dout, dout_nbytes, level); end
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h04, 1, 1);
    checks++; if (level !== 3'd1 || dout !== 32'h04030201 || dout_nbytes !== 3'd4) begin failures++; $display("FAIL flush_complete got=%0d/%h/%0d exp=1/04030201/4", level, dout, dout_nbytes); end
    cyc(0, 8'h00, 0, 1);
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL flush_drain got=%b exp=0", dout_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] words[5];
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < WB; k++) begin
        words[i][8*k +: 8] = 8'(8'h10 * (i + 1) + k);
        cyc(1, words[i][8*k +: 8], 0, 0);
      end
      if (i == 3) begin
        checks++; if (full !== 1'b1 || level !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_fill got=%b/%0d/%b exp=1/4/0", full, level, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1 || level !== 3'd4) begin failures++; $display("FAIL ovf_drop got=%b/%0d exp=1/4", overflow, level); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dout !== words[i] || dout_valid !== 1'b1) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, dout, words[i]); end
      cyc(0, 8'h00, 0, 1);
    end
    checks++; if (dout_valid !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b/%b exp=0/1", dout_valid, overflow); end
  endtask

  task automatic test_full_passthrough();
    async_reset();
    checks++; if (overflow !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL pass_reset got=%b/%0d exp=0/0", overflow, level); end
    release_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < WB; k++) cyc(1, 8'(8'h50 + 4 * i + k), 0, 0);
    cyc(1, 8'hE0, 0, 0);
    cyc(1, 8'hE1, 0, 0);
    cyc(1, 8'hE2, 0, 0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL pass_full got=%b exp=1", full); end
    cyc(1, 8'hE3, 0, 1);
    checks++; if (level !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin failures++; $display("FAIL pass_level got=%0d/%b exp=4/0", level, overflow); end
    checks++; if (dout !== 32'h57565554) begin failures++; $display("FAIL pass_head got=%h exp=57565554", dout); end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1);
    checks++; if (dout !== 32'hE3E2E1E0 || level !== 3'd0 || dout_valid !== 1'b0) begin
      // last word popped on the 4th drain cycle; nothing left
      if (dout !== 32'h0 || level !== 3'd0 || dout_valid !== 1'b0) begin failures++; $display("FAIL pass_drain got=%h/%0d/%b exp=0/0/0", dout, level, dout_valid); end
    end
  endtask

  task automatic test_reset_mid_word();
    cyc(1, 8'h10, 1, 0);
    cyc(1, 8'h77, 0, 0);
    cyc(1, 8'h88, 0, 0);
    async_reset();
    checks++; if (dout_valid !== 1'b0 || dout !== 32'h0 || level !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL midrst got=%b/%h/%0d/%b exp=0/0/0/0", dout_valid, dout, level, overflow); end
    release_reset();
    cyc(1, 8'h01, 0, 1);
    cyc(1, 8'h02, 0, 1);
    cyc(1, 8'h03, 0, 1);
    cyc(1, 8'h04, 0, 1);
    checks++; if (dout !== 32'h04030201 || dout_nbytes !== 3'd4) begin failures++; $display("FAIL midrst_word got=%h/%0d exp=04030201/4", dout, dout_nbytes); end
    cyc(0, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    int sent = 0;
    bit v, fl, rdy;
    while (sent < 200) begin
      v   = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(v, 8'($urandom), fl, rdy);
      if (v) sent++;
      checks++;
      if (dout_valid !== (m_fifo.size() > 0) || dout !== exp_dout() || dout_nbytes !== exp_nb() ||
          level !== 3'(m_fifo.size()) || full !== (m_fifo.size() == DEPTH) || overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand got=%b/%h/%0d/%0d/%b/%b exp=%b/%h/%0d/%0d/%b/%b", dout_valid, dout, dout_nbytes, level, full, overflow,
                 m_fifo.size() > 0, exp_dout(), exp_nb(), m_fifo.size(), m_fifo.size() == DEPTH, m_ovf);
      end
    end
    cyc(0, 8'h00, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 8'h00, 0, 1);
      checks++;
      if (dout_valid !== (m_fifo.size() > 0) || dout !== exp_dout() || level !== 3'(m_fifo.size())) begin
        failures++;
        $display("FAIL rand_drain got=%b/%h/%0d exp=%b/%h/%0d", dout_valid, dout, level, m_fifo.size() > 0, exp_dout(), m_fifo.size());
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_overflow();
    test_full_passthrough();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
